// File: rtl/recip_pkg.sv
// Shared types and constants for the reciprocal coefficient table writer.
package recip_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DIVIDEND  = 256;
   localparam int DIV_STEPS = 9;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 16;

   // Dividend, divisor, remainder and bit-counter widths of the divider.
   localparam int DVD_W = 9;
   localparam int DVS_W = 5;
   localparam int REM_W = 5;
   localparam int CNT_W = 4;

   localparam logic [DATA_W-1:0] SAT_VALUE = 16'd255;

endpackage

// File: rtl/recip_divider.sv
// Restoring divider: DIVIDEND / divisor, one quotient bit per step, MSB first.
module recip_divider
   import recip_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             last_step
);

   localparam logic [DVD_W-1:0] DVD_VEC = DVD_W'(DIVIDEND);

   logic [REM_W-1:0] rem_reg, rem_next;
   logic [DVD_W-1:0] quo_reg, quo_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [REM_W:0]   trial;
   logic [REM_W:0]   divisor_ext;

   assign divisor_ext = (REM_W+1)'(divisor);

   always_comb begin
      rem_next = rem_reg;
      quo_next = quo_reg;
      cnt_next = cnt_reg;
      trial    = {rem_reg, DVD_VEC[cnt_reg]};
      if (load) begin
         rem_next = '0;
         quo_next = '0;
         cnt_next = CNT_W'(DIV_STEPS - 1);
      end else if (step) begin
         // The partial remainder is always below the divisor, so it fits REM_W bits.
         if (trial >= divisor_ext) begin
            rem_next = REM_W'(trial - divisor_ext);
            quo_next = {quo_reg[DVD_W-2:0], 1'b1};
         end else begin
            rem_next = REM_W'(trial);
            quo_next = {quo_reg[DVD_W-2:0], 1'b0};
         end
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_reg <= '0;
         quo_reg <= '0;
         cnt_reg <= '0;
      end else begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         cnt_reg <= cnt_next;
      end
   end

   assign quotient  = quo_reg;
   assign last_step = (cnt_reg == '0);

endmodule

// File: rtl/recip_table_writer.sv
// Generates floor(256/(n+1)) for n = 0..LAST_INDEX and writes it over a valid/ready port.
// Optional build macro RECIP_SAT_EN: saturate the address-0 entry to 255 instead of 256.
module recip_table_writer
   import recip_pkg::*;
#(
   parameter int LAST_INDEX = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] index_reg, index_next;
   logic              div_load;
   logic              div_step;
   logic              div_last;
   logic [DVD_W-1:0]  quotient;
   logic [DVS_W-1:0]  divisor;
   logic [DATA_W-1:0] entry_data;

   assign divisor = DVS_W'(index_reg) + DVS_W'(1);

   recip_divider u_divider (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .divisor   (divisor),
      .quotient  (quotient),
      .last_step (div_last)
   );

`ifdef RECIP_SAT_EN
   assign entry_data = (index_reg == '0) ? SAT_VALUE : DATA_W'(quotient);
`else
   assign entry_data = DATA_W'(quotient);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         index_reg <= '0;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      div_load   = 1'b0;
      div_step   = 1'b0;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = DIV;
               index_next = '0;
               div_load   = 1'b1;
            end
         end
         DIV: begin
            busy     = 1'b1;
            div_step = 1'b1;
            // The step taken on the counter==0 cycle produces the final quotient bit.
            if (div_last) begin
               state_next = OUT;
            end
         end
         OUT: begin
            busy     = 1'b1;
            wr_valid = 1'b1;
            wr_addr  = index_reg;
            wr_data  = entry_data;
            if (wr_ready) begin
               if (index_reg == ADDR_W'(LAST_INDEX)) begin
                  state_next = DONE;
               end else begin
                  state_next = DIV;
                  index_next = index_reg + 1'b1;
                  div_load   = 1'b1;
               end
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
